ram_test_ctl: RTL and testbench



---
 rtl/ram_test_pkg.sv | 13 +
 rtl/ram_test_rdpipe.sv | 45 ++++
 rtl/ram_test_ctl.sv | 149 ++++++++++++++
 tb/tb_ram_test_ctl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_test_pkg.sv
// rtl/ram_test_pkg.sv - shared state encoding and default widths for the RAM test sequencer
package ram_test_pkg;
   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_DRAIN,
      ST_DONE
   } state_e;
endpackage

// File: rtl/ram_test_rdpipe.sv
// rtl/ram_test_rdpipe.sv - valid-plus-address delay line matching the RAM read latency
module ram_test_rdpipe
   import ram_test_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              valid_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic              valid_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic              pending_o
);
   logic              valid_q [DEPTH];
   logic [ADDR_W-1:0] addr_q  [DEPTH];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            addr_q[i]  <= '0;
         end
      end else begin
         valid_q[0] <= valid_i;
         addr_q[0]  <= addr_i;
         for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            addr_q[i]  <= addr_q[i-1];
         end
      end
   end

   // Entries still travelling behind the output stage; zero means the pipe empties this cycle.
   always_comb begin
      pending_o = 1'b0;
      for (int i = 0; i < DEPTH - 1; i++) begin
         pending_o = pending_o | valid_q[i];
      end
   end

   assign valid_o = valid_q[DEPTH-1];
   assign addr_o  = addr_q[DEPTH-1];
endmodule

// File: rtl/ram_test_ctl.sv
// rtl/ram_test_ctl.sv - writes seed+address across N RAM words, reads back and counts mismatches
module ram_test_ctl
   import ram_test_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int RD_LATENCY = 2
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic [ADDR_W:0]   cfg_count,
   input  logic [DATA_W-1:0] cfg_seed,
   output logic              busy,
   output logic              done,
   output logic [31:0]       err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   output logic              ram_re,
   input  logic [DATA_W-1:0] ram_rdata
);
   localparam int CNT_W = ADDR_W + 1;

   state_e              state_q;
   logic [CNT_W-1:0]    count_q;
   logic [CNT_W-1:0]    idx_q;
   logic [CNT_W-1:0]    idx_d;
   logic [DATA_W-1:0]   seed_q;
   logic                busy_q;
   logic                done_q;
   logic [31:0]         err_q;
   logic [ADDR_W-1:0]   ferr_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                we_q;
   logic                re_q;

   logic                pipe_valid;
   logic [ADDR_W-1:0]   pipe_addr;
   logic                pipe_pending;
   logic                mismatch;

   ram_test_rdpipe #(
      .DEPTH  (RD_LATENCY),
      .ADDR_W (ADDR_W)
   ) u_rdpipe (
      .clk       (clk),
      .resetn    (resetn),
      .valid_i   (re_q),
      .addr_i    (addr_q),
      .valid_o   (pipe_valid),
      .addr_o    (pipe_addr),
      .pending_o (pipe_pending)
   );

   assign idx_d    = idx_q + 1'b1;
   assign mismatch = pipe_valid && (ram_rdata != (seed_q + DATA_W'(pipe_addr)));

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         idx_q   <= '0;
         seed_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= '0;
         ferr_q  <= '1;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         re_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (mismatch) begin
            if (err_q != '1) err_q <= err_q + 1'b1;
            if (err_q == '0) ferr_q <= pipe_addr;
         end
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  count_q <= cfg_count;
                  seed_q  <= cfg_seed;
                  err_q   <= '0;
                  ferr_q  <= '1;
                  idx_q   <= '0;
                  addr_q  <= '0;
                  wdata_q <= cfg_seed;
                  if (cfg_count == '0) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_WRITE;
                     busy_q  <= 1'b1;
                     we_q    <= 1'b1;
                  end
               end
            end
            ST_WRITE: begin
               if (idx_d == count_q) begin
                  state_q <= ST_READ;
                  we_q    <= 1'b0;
                  re_q    <= 1'b1;
                  idx_q   <= '0;
                  addr_q  <= '0;
               end else begin
                  idx_q   <= idx_d;
                  addr_q  <= idx_d[ADDR_W-1:0];
                  wdata_q <= seed_q + DATA_W'(idx_d);
               end
            end
            ST_READ: begin
               if (idx_d == count_q) begin
                  state_q <= ST_DRAIN;
                  re_q    <= 1'b0;
               end else begin
                  idx_q  <= idx_d;
                  addr_q <= idx_d[ADDR_W-1:0];
               end
            end
            ST_DRAIN: begin
               // The last read is compared in this cycle once nothing is queued behind it.
               if (!pipe_pending) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign err_count      = err_q;
   assign first_err_addr = ferr_q;
   assign ram_addr       = addr_q;
   assign ram_wdata      = wdata_q;
   assign ram_we         = we_q;
   assign ram_re         = re_q;
endmodule

// File: tb/tb_ram_test_ctl.sv
// tb/tb_ram_test_ctl.sv - randomized self-checking bench for ram_test_ctl at read latencies 2 and 1
module tb_ram_test_ctl;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int CW = AW + 1;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [1:0]    start = '0;
   logic [CW-1:0] cfg_count = '0;
   logic [DW-1:0] cfg_seed = '0;
   logic [1:0]    busy, done, ram_we, ram_re;
   logic [31:0]   err_count [2];
   logic [AW-1:0] first_err_addr [2];
   logic [AW-1:0] ram_addr [2];
   logic [DW-1:0] ram_wdata [2];
   logic [DW-1:0] ram_rdata [2];

   int bad1 = -1;
   int bad2 = -1;
   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] flip(input logic [AW-1:0] a);
      return (int'(a) == bad1 || int'(a) == bad2) ? 32'h8000_0001 : '0;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int L = (g == 0) ? 2 : 1;
      logic [DW-1:0] mem [0:(1<<AW)-1];
      logic [DW-1:0] rpipe [L];

      ram_test_ctl #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(L)) u_dut (
         .clk(clk), .resetn(resetn), .start(start[g]), .cfg_count(cfg_count), .cfg_seed(cfg_seed),
         .busy(busy[g]), .done(done[g]), .err_count(err_count[g]), .first_err_addr(first_err_addr[g]),
         .ram_addr(ram_addr[g]), .ram_wdata(ram_wdata[g]), .ram_we(ram_we[g]), .ram_re(ram_re[g]),
         .ram_rdata(ram_rdata[g])
      );

      always @(posedge clk) begin
         if (ram_we[g]) mem[ram_addr[g]] <= ram_wdata[g];
         rpipe[0] <= ram_re[g] ? (mem[ram_addr[g]] ^ flip(ram_addr[g])) : 32'hDEAD_BEEF;
         for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
      end
      assign ram_rdata[g] = rpipe[L-1];
   end

   int            sel = 0;
   bit            mon_en = 1'b0;
   logic [AW-1:0] wa[$], ra[$];
   logic [DW-1:0] wd[$];
   int            wc[$], rc[$];
   int            overlap, busy_n, busy_first, busy_last, done_n, done_cyc, t_start;
   logic [31:0]   done_err;
   logic [AW-1:0] done_ferr;

   always @(negedge clk) begin
      if (mon_en) begin
         if (ram_we[sel]) begin wa.push_back(ram_addr[sel]); wd.push_back(ram_wdata[sel]); wc.push_back(cyc); end
         if (ram_re[sel]) begin ra.push_back(ram_addr[sel]); rc.push_back(cyc); end
         if (ram_we[sel] && ram_re[sel]) overlap++;
         if (busy[sel]) begin if (busy_n == 0) busy_first = cyc; busy_last = cyc; busy_n++; end
         if (done[sel]) begin done_n++; done_cyc = cyc; done_err = err_count[sel]; done_ferr = first_err_addr[sel]; end
      end
   end

   task automatic launch(input int g, input int n, input logic [DW-1:0] seed);
      @(posedge clk); #1;
      wa.delete(); wd.delete(); wc.delete(); ra.delete(); rc.delete();
      overlap = 0; busy_n = 0; done_n = 0; done_cyc = -1; busy_first = -1; busy_last = -1;
      sel = g; mon_en = 1'b1;
      cfg_count = CW'(n); cfg_seed = seed; start[g] = 1'b1; t_start = cyc;
      @(posedge clk); #1;
      start[g] = 1'b0; cfg_count = CW'($urandom); cfg_seed = $urandom;
   endtask

   task automatic wait_done(input int limit, output bit to);
      to = 1'b1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (done[sel]) begin to = 1'b0; break; end
      end
      repeat (3) @(negedge clk);
      mon_en = 1'b0;
   endtask

   task automatic test_reset;
      resetn = 1'b0; start = 2'b11; cfg_count = 17'd5;
      repeat (3) @(posedge clk); #1;
      start = '0;
      for (int g = 0; g < 2; g++) begin
         n_checks++; if (busy[g] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b expected 0", g, busy[g]); end
         n_checks++; if (done[g] !== 1'b0) begin n_fail++; $display("FAIL reset_done[%0d]: got %b expected 0", g, done[g]); end
         n_checks++; if (err_count[g] !== 32'd0) begin n_fail++; $display("FAIL reset_err[%0d]: got %0h expected 0", g, err_count[g]); end
         n_checks++; if (first_err_addr[g] !== 16'hFFFF) begin n_fail++; $display("FAIL reset_ferr[%0d]: got %0h expected ffff", g, first_err_addr[g]); end
         n_checks++; if (ram_addr[g] !== 16'd0 || ram_wdata[g] !== 32'd0) begin n_fail++; $display("FAIL reset_bus[%0d]: got addr %0h data %0h expected 0 0", g, ram_addr[g], ram_wdata[g]); end
         n_checks++; if (ram_we[g] !== 1'b0 || ram_re[g] !== 1'b0) begin n_fail++; $display("FAIL reset_strobes[%0d]: got we %b re %b expected 0 0", g, ram_we[g], ram_re[g]); end
      end
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (busy !== 2'b00) begin n_fail++; $display("FAIL reset_no_start: got busy %b expected 00", busy); end
   endtask

   task automatic test_clean;
      bit to;
      int bad_w = 0, bad_r = 0;
      launch(0, 4, 32'h100);
      wait_done(40, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL clean_timeout: got no done expected done"); end
      for (int i = 0; i < wa.size(); i++) if (wa[i] !== AW'(i) || wd[i] !== 32'h100 + DW'(i) || wc[i] != t_start + 1 + i) bad_w++;
      for (int i = 0; i < ra.size(); i++) if (ra[i] !== AW'(i) || rc[i] != t_start + 5 + i) bad_r++;
      n_checks++; if (wa.size() != 4 || bad_w != 0) begin n_fail++; $display("FAIL clean_writes: got %0d writes %0d wrong expected 4 0", wa.size(), bad_w); end
      n_checks++; if (ra.size() != 4 || bad_r != 0) begin n_fail++; $display("FAIL clean_reads: got %0d reads %0d wrong expected 4 0", ra.size(), bad_r); end
      n_checks++; if (done_cyc != t_start + 11) begin n_fail++; $display("FAIL clean_done_cycle: got %0d expected %0d", done_cyc, t_start + 11); end
      n_checks++; if (done_err !== 32'd0 || done_ferr !== 16'hFFFF) begin n_fail++; $display("FAIL clean_result: got err %0d ferr %0h expected 0 ffff", done_err, done_ferr); end
      n_checks++; if (busy_first != t_start + 1 || busy_last != t_start + 10) begin n_fail++; $display("FAIL clean_busy: got %0d..%0d expected %0d..%0d", busy_first, busy_last, t_start + 1, t_start + 10); end
      n_checks++; if (overlap != 0 || done_n != 1) begin n_fail++; $display("FAIL clean_overlap_done: got overlap %0d dones %0d expected 0 1", overlap, done_n); end
   endtask

   task automatic test_errors;
      bit to;
      bad1 = 5; bad2 = 9;
      launch(0, 16, $urandom);
      wait_done(80, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL errors_timeout: got no done expected done"); end
      n_checks++; if (done_err !== 32'd2) begin n_fail++; $display("FAIL errors_count: got %0d expected 2", done_err); end
      n_checks++; if (done_ferr !== 16'd5) begin n_fail++; $display("FAIL errors_first: got %0h expected 5", done_ferr); end
      n_checks++; if (done_cyc != t_start + 35) begin n_fail++; $display("FAIL errors_done_cycle: got %0d expected %0d", done_cyc, t_start + 35); end
      n_checks++; if (err_count[0] !== 32'd2 || first_err_addr[0] !== 16'd5) begin n_fail++; $display("FAIL errors_hold: got %0d %0h expected 2 5", err_count[0], first_err_addr[0]); end
      bad1 = -1; bad2 = -1;
   endtask

   task automatic test_zero;
      bit to;
      launch(0, 0, $urandom);
      wait_done(10, to);
      n_checks++; if (to || done_cyc != t_start + 1) begin n_fail++; $display("FAIL zero_done_cycle: got %0d expected %0d", done_cyc, t_start + 1); end
      n_checks++; if (busy_n != 0) begin n_fail++; $display("FAIL zero_busy: got %0d busy cycles expected 0", busy_n); end
      n_checks++; if (wa.size() != 0 || ra.size() != 0) begin n_fail++; $display("FAIL zero_strobes: got %0d writes %0d reads expected 0 0", wa.size(), ra.size()); end
      n_checks++; if (done_err !== 32'd0 || done_ferr !== 16'hFFFF) begin n_fail++; $display("FAIL zero_result: got err %0d ferr %0h expected 0 ffff", done_err, done_ferr); end
   endtask

   task automatic test_start_while_busy;
      bit to = 1'b1;
      launch(0, 6, 32'hA000_0000);
      @(posedge clk); #1;
      start[0] = 1'b1; cfg_count = 17'd3;
      @(posedge clk); #1;
      start[0] = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done[0]) begin to = 1'b0; start[0] = 1'b1; cfg_count = 17'd5; break; end
      end
      @(posedge clk); #1;
      start[0] = 1'b0;
      repeat (8) @(negedge clk);
      mon_en = 1'b0;
      n_checks++; if (to) begin n_fail++; $display("FAIL busy_start_timeout: got no done expected done"); end
      n_checks++; if (done_n != 1 || done_cyc != t_start + 15) begin n_fail++; $display("FAIL busy_start_done: got %0d dones at %0d expected 1 at %0d", done_n, done_cyc, t_start + 15); end
      n_checks++; if (wa.size() != 6 || ra.size() != 6) begin n_fail++; $display("FAIL busy_start_len: got %0d/%0d expected 6/6", wa.size(), ra.size()); end
      n_checks++; if (busy_n != 14 || busy_last != t_start + 14) begin n_fail++; $display("FAIL busy_start_busy: got %0d ending %0d expected 14 ending %0d", busy_n, busy_last, t_start + 14); end
   endtask

   task automatic test_reset_mid;
      bit seen = 1'b0;
      bit to;
      launch(0, 8, 32'h55AA_0000);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ram_re[0] && ram_addr[0] == 16'd3) begin seen = 1'b1; break; end
      end
      n_checks++; if (!seen) begin n_fail++; $display("FAIL mid_reset_read3: got no read of 3 expected one"); end
      resetn = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (ram_we[0] !== 1'b0 || ram_re[0] !== 1'b0 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin n_fail++; $display("FAIL mid_reset_outputs: got we %b re %b busy %b done %b expected 0 0 0 0", ram_we[0], ram_re[0], busy[0], done[0]); end
      n_checks++; if (err_count[0] !== 32'd0 || first_err_addr[0] !== 16'hFFFF) begin n_fail++; $display("FAIL mid_reset_status: got %0d %0h expected 0 ffff", err_count[0], first_err_addr[0]); end
      @(posedge clk); #1;
      resetn = 1'b1;
      repeat (20) @(negedge clk);
      mon_en = 1'b0;
      n_checks++; if (done_n != 0) begin n_fail++; $display("FAIL mid_reset_no_done: got %0d dones expected 0", done_n); end
      launch(0, 2, $urandom);
      wait_done(30, to);
      n_checks++; if (to || done_cyc != t_start + 7 || wa.size() != 2) begin n_fail++; $display("FAIL mid_reset_rerun: got done %0d writes %0d expected %0d 2", done_cyc, wa.size(), t_start + 7); end
      n_checks++; if (done_err !== 32'd0 || done_ferr !== 16'hFFFF) begin n_fail++; $display("FAIL mid_reset_rerun_result: got %0d %0h expected 0 ffff", done_err, done_ferr); end
   endtask

   task automatic test_seed_wrap;
      bit to;
      logic [DW-1:0] exp_d [4];
      int bad_w = 0;
      exp_d[0] = 32'hFFFF_FFFE; exp_d[1] = 32'hFFFF_FFFF; exp_d[2] = 32'h0; exp_d[3] = 32'h1;
      launch(1, 4, 32'hFFFF_FFFE);
      wait_done(40, to);
      for (int i = 0; i < wd.size() && i < 4; i++) if (wd[i] !== exp_d[i]) bad_w++;
      n_checks++; if (wd.size() != 4 || bad_w != 0) begin n_fail++; $display("FAIL wrap_data: got %0d words %0d wrong expected 4 0", wd.size(), bad_w); end
      n_checks++; if (to || done_cyc != t_start + 10) begin n_fail++; $display("FAIL wrap_done_cycle: got %0d expected %0d", done_cyc, t_start + 10); end
      n_checks++; if (done_err !== 32'd0) begin n_fail++; $display("FAIL wrap_err: got %0d expected 0", done_err); end
   endtask

   task automatic test_random;
      bit to;
      for (int it = 0; it < 10; it++) begin
         int g = $urandom_range(0, 1);
         int lat = (g == 0) ? 2 : 1;
         int n = $urandom_range(1, 120);
         logic [DW-1:0] seed = $urandom;
         int exp_err = 0;
         logic [AW-1:0] exp_ferr = '1;
         int bad_w = 0, bad_r = 0;
         bad1 = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, n + 4));
         bad2 = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, n + 4));
         for (int a = 0; a < n; a++) if (a == bad1 || a == bad2) begin if (exp_err == 0) exp_ferr = AW'(a); exp_err++; end
         launch(g, n, seed);
         wait_done(2 * n + 20, to);
         for (int i = 0; i < wa.size(); i++) if (wa[i] !== AW'(i) || wd[i] !== seed + DW'(i) || wc[i] != t_start + 1 + i) bad_w++;
         for (int i = 0; i < ra.size(); i++) if (ra[i] !== AW'(i) || rc[i] != t_start + n + 1 + i) bad_r++;
         n_checks++; if (to || done_n != 1 || done_cyc != t_start + 2 * n + lat + 1) begin n_fail++; $display("FAIL rand%0d_done: got %0d dones at %0d expected 1 at %0d", it, done_n, done_cyc, t_start + 2 * n + lat + 1); end
         n_checks++; if (wa.size() != n || bad_w != 0 || overlap != 0) begin n_fail++; $display("FAIL rand%0d_writes: got %0d writes %0d wrong overlap %0d expected %0d 0 0", it, wa.size(), bad_w, overlap, n); end
         n_checks++; if (ra.size() != n || bad_r != 0) begin n_fail++; $display("FAIL rand%0d_reads: got %0d reads %0d wrong expected %0d 0", it, ra.size(), bad_r, n); end
         n_checks++; if (done_err !== 32'(exp_err) || done_ferr !== exp_ferr) begin n_fail++; $display("FAIL rand%0d_result: got err %0d ferr %0h expected %0d %0h", it, done_err, done_ferr, exp_err, exp_ferr); end
         n_checks++; if (busy_n != 2 * n + lat) begin n_fail++; $display("FAIL rand%0d_busy: got %0d expected %0d", it, busy_n, 2 * n + lat); end
      end
      bad1 = -1; bad2 = -1;
   endtask

   initial begin
      test_reset();
      test_clean();
      test_errors();
      test_zero();
      test_start_while_busy();
      test_reset_mid();
      test_seed_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
